// File: rtl/char_scroller_if.sv
// Bundle of load handshake, scroll controls and display outputs for char_scroller.
// Latency: none; this only groups signals.
// Backpressure: load_valid is held by the master until load_ready is seen high.
interface char_scroller_if;
  logic        load_valid;
  logic        load_ready;
  logic [14:0] char_in;
  logic        run;
  logic        dir;
  logic [2:0]  rot;
  logic [23:0] disp_codes;
  logic        step;
  logic [1:0]  state;

  modport master (
    output load_valid, char_in, run, dir,
    input  load_ready, rot, disp_codes, step, state
  );

  modport slave (
    input  load_valid, char_in, run, dir,
    output load_ready, rot, disp_codes, step, state
  );
endinterface

// File: rtl/char_scroller.sv
// Rotates a five-letter message plus three blanks across eight display positions.
// Latency: load/run take effect on the next edge; disp_codes is combinational from registers.
// Backpressure: load_ready is low while scrolling (RUN); a held load_valid is taken in IDLE/PAUSE.
module char_scroller #(
  parameter int unsigned TICK_DIV = 25000000
) (
  input  logic       CLOCK_50,
  input  logic       RESET_N,
  char_scroller_if.slave bus
);

  localparam int unsigned   PW       = $clog2(TICK_DIV);
  localparam logic [PW-1:0] PRE_LAST = PW'(TICK_DIV - 1);

  typedef enum logic [1:0] {
    IDLE  = 2'b00,
    RUN   = 2'b01,
    PAUSE = 2'b10
  } state_t;

  state_t        state_q, state_d;
  logic [PW-1:0] pre_q, pre_d;
  logic [2:0]    rot_q, rot_d;
  logic [2:0]    msg_q [5];
  logic [2:0]    win   [8];
  logic          load_acc;
  logic          wrap;

  assign bus.load_ready = (state_q != RUN);
  assign load_acc       = bus.load_valid && bus.load_ready;
  // The wrap cycle is the one whose closing edge moves rot; a load can never
  // coincide with it because loads are refused in RUN.
  assign wrap           = (state_q == RUN) && (pre_q == PRE_LAST);
  assign bus.step       = wrap;
  assign bus.rot        = rot_q;
  assign bus.state      = state_q;

  // Next state, prescaler and rotation; a load overrides everything else.
  always_comb begin
    state_d = state_q;
    pre_d   = pre_q;
    rot_d   = rot_q;
    if (load_acc) begin
      state_d = IDLE;
      pre_d   = '0;
      rot_d   = '0;
    end else begin
      case (state_q)
        IDLE: begin
          pre_d = '0;
          if (bus.run) state_d = RUN;
        end
        RUN: begin
          if (wrap) begin
            pre_d = '0;
            rot_d = bus.dir ? (rot_q - 3'd1) : (rot_q + 3'd1);
          end else begin
            pre_d = pre_q + 1'b1;
          end
          if (!bus.run) state_d = PAUSE;
        end
        PAUSE: begin
          if (bus.run) state_d = RUN;
        end
        default: begin
          state_d = IDLE;
          pre_d   = '0;
        end
      endcase
    end
  end

  // FSM state register.
  always_ff @(posedge CLOCK_50 or negedge RESET_N) begin
    if (!RESET_N) state_q <= IDLE;
    else          state_q <= state_d;
  end

  // Prescaler, rotation and message buffer; blanks after reset.
  always_ff @(posedge CLOCK_50 or negedge RESET_N) begin
    if (!RESET_N) begin
      pre_q <= '0;
      rot_q <= '0;
      for (int i = 0; i < 5; i++) msg_q[i] <= 3'b111;
    end else begin
      pre_q <= pre_d;
      rot_q <= rot_d;
      if (load_acc) begin
        for (int i = 0; i < 5; i++) msg_q[i] <= bus.char_in[3*i +: 3];
      end
    end
  end

  // Window is the message followed by three blanks; position p shows W[p - rot].
  always_comb begin
    for (int i = 0; i < 5; i++) win[i] = msg_q[i];
    for (int i = 5; i < 8; i++) win[i] = 3'b111;
  end

  for (genvar p = 0; p < 8; p++) begin : g_pos
    assign bus.disp_codes[3*p +: 3] = win[3'(p) - rot_q];
  end

endmodule

// File: tb/tb_char_scroller.sv
// Self-checking bench for char_scroller with TICK_DIV=4.
// Latency: n/a.
// Backpressure: n/a.
module tb_char_scroller;
  localparam int TD = 4;

  logic CLOCK_50 = 1'b0;
  logic RESET_N;
  char_scroller_if bus ();

  char_scroller #(.TICK_DIV(TD)) dut (
    .CLOCK_50 (CLOCK_50),
    .RESET_N  (RESET_N),
    .bus      (bus)
  );

  always #5 CLOCK_50 = ~CLOCK_50;

  int n_checks = 0;
  int n_err    = 0;
  int step_seen = 0;
  bit chk_en   = 1'b0;

  // Reference model: 0=idle, 1=run, 2=pause
  int m_state, m_pre, m_rot;
  int m_msg [5];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s at t=%0t: got %0h expected %0h", name, $time, act, exp);
    end
  endtask

  function automatic logic [23:0] model_disp();
    logic [23:0] d;
    d = '0;
    for (int p = 0; p < 8; p++) begin
      int w;
      w = (p - m_rot + 8) % 8;
      d[3*p +: 3] = (w < 5) ? 3'(m_msg[w]) : 3'b111;
    end
    return d;
  endfunction

  // Model advances on each clock edge from the spec's rules.
  always @(posedge CLOCK_50 or negedge RESET_N) begin
    if (!RESET_N) begin
      m_state = 0; m_pre = 0; m_rot = 0;
      for (int i = 0; i < 5; i++) m_msg[i] = 7;
    end else if (bus.load_valid && m_state != 1) begin
      for (int i = 0; i < 5; i++) m_msg[i] = (bus.char_in >> (3*i)) & 7;
      m_rot = 0; m_pre = 0; m_state = 0;
    end else if (m_state == 0) begin
      if (bus.run) m_state = 1;
    end else if (m_state == 1) begin
      if (m_pre == TD - 1) begin
        m_pre = 0;
        m_rot = bus.dir ? (m_rot + 7) % 8 : (m_rot + 1) % 8;
      end else begin
        m_pre = m_pre + 1;
      end
      if (!bus.run) m_state = 2;
    end else begin
      if (bus.run) m_state = 1;
    end
  end

  // Every-cycle comparison against the model, away from the active edge.
  always @(negedge CLOCK_50) begin
    if (chk_en) begin
      chk("rot",        32'(bus.rot),        32'(m_rot));
      chk("state",      32'(bus.state),      32'(m_state));
      chk("disp_codes", 32'(bus.disp_codes), 32'(model_disp()));
      chk("load_ready", 32'(bus.load_ready), 32'(m_state != 1));
      chk("step",       32'(bus.step),       32'(m_state == 1 && m_pre == TD - 1));
      if (bus.step) step_seen++;
    end
  end

  task automatic cycles(input int n);
    repeat (n) @(posedge CLOCK_50);
    #2;
  endtask

  int s0;

  initial begin
    RESET_N = 1'b1;
    bus.load_valid = 1'b0; bus.char_in = '0; bus.run = 1'b0; bus.dir = 1'b0;
    #1 RESET_N = 1'b0;
    #1;
    // Reset takes effect with no clock edge
    chk("rst_disp",  32'(bus.disp_codes), 32'hFFFFFF);
    chk("rst_ready", 32'(bus.load_ready), 32'd1);
    chk("rst_state", 32'(bus.state),      32'd0);
    chk("rst_rot",   32'(bus.rot),        32'd0);
    chk("rst_step",  32'(bus.step),       32'd0);
    cycles(2);

    // Load on the first edge after release
    RESET_N = 1'b1; chk_en = 1'b1;
    bus.load_valid = 1'b1; bus.char_in = 15'o43210;
    cycles(1);
    bus.load_valid = 1'b0;
    chk("load_disp",  32'(bus.disp_codes), 32'(24'o77743210));
    chk("load_rot",   32'(bus.rot),        32'd0);
    chk("load_state", 32'(bus.state),      32'd0);

    // Scroll left for 9 cycles
    bus.run = 1'b1; bus.dir = 1'b0; s0 = step_seen;
    cycles(9);
    chk("run9_rot",   32'(bus.rot),        32'd2);
    chk("run9_state", 32'(bus.state),      32'd1);
    chk("run9_disp",  32'(bus.disp_codes), 32'(24'o74321077));
    chk("run9_steps", 32'(step_seen - s0), 32'd2);

    // Load attempt while running is ignored
    bus.load_valid = 1'b1; bus.char_in = 15'o01234;
    cycles(1);
    bus.load_valid = 1'b0;
    chk("ign_disp",  32'(bus.disp_codes), 32'(24'o74321077));
    chk("ign_ready", 32'(bus.load_ready), 32'd0);

    // Pause with prescaler at 2, then resume
    bus.run = 1'b0;
    cycles(1);
    chk("pause_state", 32'(bus.state), 32'd2);
    cycles(10);
    chk("pause_rot",   32'(bus.rot),   32'd2);
    chk("pause_hold",  32'(bus.state), 32'd2);
    bus.run = 1'b1;
    cycles(1);
    chk("resume_state", 32'(bus.state), 32'd1);
    chk("resume_step0", 32'(bus.step),  32'd0);
    cycles(1);
    chk("resume_step1", 32'(bus.step),  32'd1);
    chk("resume_rot2",  32'(bus.rot),   32'd2);
    cycles(1);
    chk("resume_rot3",  32'(bus.rot),   32'd3);

    // Drop run on the wrap cycle
    cycles(3);
    chk("wrap_step", 32'(bus.step), 32'd1);
    bus.run = 1'b0;
    cycles(1);
    chk("wrapdrop_rot",   32'(bus.rot),   32'd4);
    chk("wrapdrop_state", 32'(bus.state), 32'd2);
    bus.run = 1'b1;
    cycles(4);
    chk("wrapdrop_pre0", 32'(bus.step), 32'd1);
    cycles(1);
    chk("rot5", 32'(bus.rot), 32'd5);

    // Asynchronous reset mid-count
    cycles(2);
    #1 RESET_N = 1'b0;
    #1;
    chk("arst_rot",   32'(bus.rot),        32'd0);
    chk("arst_state", 32'(bus.state),      32'd0);
    chk("arst_disp",  32'(bus.disp_codes), 32'hFFFFFF);
    chk("arst_ready", 32'(bus.load_ready), 32'd1);
    chk("arst_step",  32'(bus.step),       32'd0);
    cycles(2);
    bus.run = 1'b0; RESET_N = 1'b1; s0 = step_seen;
    cycles(6);
    chk("post_rst_steps", 32'(step_seen - s0), 32'd0);
    chk("post_rst_state", 32'(bus.state),      32'd0);

    // Load in IDLE, run, pause, then load+run together in PAUSE
    bus.load_valid = 1'b1; bus.char_in = 15'o01234;
    cycles(1);
    bus.load_valid = 1'b0;
    chk("load2_disp", 32'(bus.disp_codes), 32'(24'o77701234));
    bus.run = 1'b1;
    cycles(1);
    bus.run = 1'b0;
    cycles(1);
    chk("pause2_state", 32'(bus.state), 32'd2);
    bus.load_valid = 1'b1; bus.run = 1'b1; bus.char_in = 15'o43210;
    cycles(1);
    bus.load_valid = 1'b0;
    chk("loadrun_state", 32'(bus.state), 32'd0);
    chk("loadrun_rot",   32'(bus.rot),   32'd0);
    cycles(1);
    chk("loadrun_run", 32'(bus.state), 32'd1);

    // dir only matters on the wrap cycle: right step 0 -> 7
    bus.dir = 1'b0;
    cycles(3);
    bus.dir = 1'b1;
    cycles(1);
    chk("right_rot",  32'(bus.rot),        32'd7);
    chk("right_disp", 32'(bus.disp_codes), 32'(24'o07774321));
    // dir flipped mid-count, left step 7 -> 0
    cycles(2);
    bus.dir = 1'b0;
    cycles(2);
    chk("left_wrap_rot", 32'(bus.rot), 32'd0);

    bus.run = 1'b0;
    cycles(2);
    chk_en = 1'b0;
    $display("Result: errors=%0d of %0d checks", n_err, n_checks);
    $finish;
  end

endmodule

// File: doc/char_scroller.md
CHAR_SCROLLER -- requirements
Module: char_scroller

Interface
REQ-001 The block SHALL have one parameter: TICK_DIV, default 25000000, clock cycles per rotation step (0.5 s at 50 MHz); legal range 2..2^26.
REQ-002 The block SHALL have one clock and an asynchronous, active-low reset; ports are listed below, clock and reset first.
REQ-003 CLOCK_50  in  1  system clock; all state changes on its rising edge.
REQ-004 RESET_N  in  1  asynchronous active-low reset.
REQ-005 load_valid  in  1  request to capture a new five-letter message.
REQ-006 load_ready  out  1  block accepts a load this cycle.
REQ-007 char_in  in  15  five 3-bit letter codes: c0=[2:0], c1=[5:3], c2=[8:6], c3=[11:9], c4=[14:12].
REQ-008 run  in  1  level: 1 = scroll, 0 = hold.
REQ-009 dir  in  1  0 = rotate left (rot+1), 1 = rotate right (rot-1).
REQ-010 rot  out  3  current rotation amount, 0..7.
REQ-011 disp_codes  out  24  eight 3-bit codes, position p in bits [3p+2:3p], one per HEX0..HEX7; 3'b111 = blank.
REQ-012 step  out  1  one-cycle pulse in the cycle rot changes.
REQ-013 state  out  2  IDLE=00, RUN=01, PAUSE=10 (11 unused).

Function
REQ-014 Message buffer SHALL be five 3-bit registers m0..m4, written only on load acceptance (load_valid && load_ready).
REQ-015 Window W SHALL be {W0..W7} = {m0, m1, m2, m3, m4, 111, 111, 111}.
REQ-016 disp_codes position p SHALL equal W[(p - rot) mod 8], decoded combinationally from registered m0..m4 and rot.
REQ-017 FSM states SHALL be IDLE, RUN, PAUSE.
REQ-018 IDLE: rot held, prescaler held at 0; run=1 -> RUN next cycle.
REQ-019 RUN: prescaler increments each cycle; at TICK_DIV-1 it wraps to 0, rot advances, step=1 for that cycle; run=0 -> PAUSE next cycle.
REQ-020 PAUSE: rot and prescaler held at current values; run=1 -> RUN, resuming the count where it stopped.
REQ-021 load_ready SHALL be 1 in IDLE and PAUSE, 0 in RUN (combinational from state).
REQ-022 Load acceptance SHALL, in the same edge, capture char_in, set rot=0, clear the prescaler, enter IDLE.
REQ-023 Load acceptance and run=1 in the same cycle: load wins; RUN is entered the following cycle if run is still 1.
REQ-024 rot SHALL wrap modulo 8: dir=0, 7->0; dir=1, 0->7.
REQ-025 dir SHALL be sampled only on the wrap cycle; a dir change mid-count affects the next step only.
REQ-026 run deasserted on the wrap cycle: the step still occurs, then PAUSE with prescaler=0.
REQ-027 load_valid while load_ready=0 SHALL be ignored with no buffer change; the source holds it until accepted.
REQ-028 Prescaler width SHALL be ceil(log2(TICK_DIV)) bits; there are no other counters.

Reset
REQ-029 RESET_N=0 SHALL immediately force state=IDLE, rot=0, prescaler=0, m0..m4=111, step=0, independent of CLOCK_50.
REQ-030 During reset disp_codes SHALL be all ones (24'hFFFFFF) and load_ready=1.
REQ-031 Reset asserted mid-RUN SHALL abandon the count with no residual step pulse after release.
REQ-032 After release the block SHALL act on the first rising edge; a load on that edge is accepted.

Verification (TICK_DIV=4)
REQ-033 Reset, load char_in=15'o43210 -> disp_codes HEX0..HEX7 = 0,1,2,3,4,7,7,7; rot=0; state=IDLE.
REQ-034 run=1, dir=0 for 9 cycles -> state RUN after 1 cycle; step pulses every 4th cycle; rot=2 at the end; HEX2 shows 0, HEX0 and HEX1 show 7.
REQ-035 dir=1 from rot=0 -> after one step rot=7, HEX0 shows 1, HEX7 shows 0.
REQ-036 Drop run at prescaler=2, wait 10 cycles, raise run -> rot unchanged in PAUSE; next step exactly 2 cycles after re-entering RUN; load accepted during PAUSE -> rot=0, IDLE.
REQ-037 Pulse load_valid in RUN -> load_ready=0, buffer unchanged; load_valid and run both 1 in PAUSE -> IDLE, then RUN.
REQ-038 Assert RESET_N=0 asynchronously mid-count at rot=5 -> outputs reach reset values before the next clock edge; no step pulse after release.
